// File: rtl/orao_tap_recorder_pkg.sv
// Shared types and TAP byte encoding for the Orao cassette-out recorder.
package orao_tape_pkg;

  typedef enum logic [2:0] {IDLE, ARMED, RECORD, DRAIN, DONE} rec_state_t;

  localparam logic [7:0] TAP_HI = 8'h40;
  localparam logic [7:0] TAP_LO = 8'h00;

  function automatic logic [7:0] tap_byte(input logic lvl);
    return lvl ? TAP_HI : TAP_LO;
  endfunction

endpackage

// File: rtl/orao_tap_recorder_fifo.sv
// Byte FIFO with registered read data; extra pointer MSB separates full from empty.
module tap_fifo #(
  parameter int AW = 12
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty && !clr;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop) && !clr;

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/orao_tap_recorder.sv
// Cassette-out capture: samples tape_out into TAP bytes and streams them over ioctl upload.
module orao_tap_recorder
  import orao_tape_pkg::*;
#(
  parameter int FIFO_AW     = 12,
  parameter int SAMPLE_DIV  = 20,
  parameter int SILENCE_MAX = 25000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_1m,
  input  logic        tape_out,
  input  logic        arm,
  input  logic        stop,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  output logic [26:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        upload_req,
  output logic        busy,
  output logic        overflow,
  output logic [23:0] byte_count
);
  localparam int DW = $clog2(SAMPLE_DIV + 1);
  localparam int SW = $clog2(SILENCE_MAX + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [SW-1:0] SIL_LAST = SW'(SILENCE_MAX - 1);

  rec_state_t  state;
  logic        arm_d, stop_d, tape_d, upl_d, pop_d;
  logic [DW-1:0] div_cnt;
  logic [SW-1:0] sil_cnt;
  logic [26:0] rd_cnt;
  logic        arm_e, stop_e, tape_e, upl_fall, arm_go;
  logic        strobe, pop_ok, push_ok, start, flush, fifo_clr;
  logic        fifo_full, fifo_empty;
  logic [7:0]  samp_byte;

  assign arm_e     = arm & ~arm_d;
  assign stop_e    = stop & ~stop_d;
  assign tape_e    = tape_out ^ tape_d;
  assign upl_fall  = upl_d & ~ioctl_upload;
  assign arm_go    = arm_e & ~stop_e;
  assign strobe    = (state == RECORD) && ce_1m && (div_cnt == DIV_LAST);
  assign pop_ok    = ioctl_upload && ioctl_rd && !fifo_empty;
  assign push_ok   = strobe && (!fifo_full || pop_ok);
  assign start     = arm_go && ((state == IDLE) || (state == DONE));
  assign flush     = (state == DRAIN) && upl_fall;
  assign fifo_clr  = start | flush;
  assign samp_byte = tap_byte(tape_out);

  assign busy       = (state != IDLE);
  assign ioctl_wait = (state == RECORD) && fifo_empty;

  tap_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clr     (fifo_clr),
    .push    (strobe),
    .pop     (pop_ok),
    .din     (samp_byte),
    .dout    (ioctl_din),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      arm_d      <= 1'b1;  // a level already high at reset must not look like an edge
      stop_d     <= 1'b1;
      tape_d     <= 1'b0;
      upl_d      <= 1'b0;
      pop_d      <= 1'b0;
      div_cnt    <= '0;
      sil_cnt    <= '0;
      rd_cnt     <= '0;
      ioctl_addr <= '0;
      upload_req <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
    end else begin
      arm_d  <= arm;
      stop_d <= stop;
      tape_d <= tape_out;
      upl_d  <= ioctl_upload;
      pop_d  <= pop_ok;

      if (pop_ok) begin
        ioctl_addr <= rd_cnt;
        rd_cnt     <= rd_cnt + 27'd1;
      end

      if (strobe) begin
        if (!push_ok) overflow <= 1'b1;
        else if (byte_count != 24'hFFFFFF) byte_count <= byte_count + 24'd1;
      end

      if (state == RECORD) begin
        if (ce_1m) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        if (tape_e) sil_cnt <= '0;
        else if (strobe) sil_cnt <= sil_cnt + SW'(1);
      end

      // A new session wipes the bookkeeping of the previous one.
      if (start) begin
        state      <= ARMED;
        overflow   <= 1'b0;
        byte_count <= '0;
        ioctl_addr <= '0;
        rd_cnt     <= '0;
        sil_cnt    <= '0;
      end else begin
        case (state)
          IDLE: ;
          ARMED: begin
            if (stop_e) state <= IDLE;
            else if (tape_e) begin
              state      <= RECORD;
              div_cnt    <= '0;
              sil_cnt    <= '0;
              upload_req <= 1'b1;
            end
          end
          RECORD: begin
            if (stop_e || (strobe && !tape_e && sil_cnt == SIL_LAST)) state <= DRAIN;
          end
          DRAIN: begin
            if (upl_fall) begin
              state      <= IDLE;
              upload_req <= 1'b0;
            end else if (fifo_empty && !pop_d) begin
              state      <= DONE;
              upload_req <= 1'b0;
            end
          end
          DONE: begin
            if (upl_fall) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
